// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM state
// type and lane-position helpers used by both the top and the lane aligner.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;   // behaves as a word access

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } mau_state_e;

    // Bit position of the byte addressed by off within a memory word.
    function automatic logic [4:0] byte_shift(input logic [1:0] off, input logic big_endian);
        return big_endian ? {~off, 3'b000} : {off, 3'b000};
    endfunction

    // Bit position of the halfword selected by hsel (address bit 1).
    function automatic logic [4:0] half_shift(input logic hsel, input logic big_endian);
        return ((big_endian ? ~hsel : hsel) == 1'b1) ? 5'd16 : 5'd0;
    endfunction

    // Halfwords need bit 0 clear, words need bits 1:0 clear; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling for the load/store unit: extracts and extends
// the addressed byte/halfword of a read word, and merges store data into the
// addressed lane of a read word for read-modify-write.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] merge_o
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane extract with sign/zero extension, and lane merge for sub-word stores.
    always_comb begin
        bsh    = byte_shift(offset_i, BIG_ENDIAN);
        hsh    = half_shift(offset_i[1], BIG_ENDIAN);
        lane_b = 8'(rdata_i >> bsh);
        lane_h = 16'(rdata_i >> hsh);
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = unsigned_i ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merge_o   = (rdata_i & ~(32'h0000_00FF << bsh)) | ({24'd0, wdata_i[7:0]} << bsh);
            end
            SZ_HALF: begin
                ld_data_o = unsigned_i ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
                merge_o   = (rdata_i & ~(32'h0000_FFFF << hsh)) | ({16'd0, wdata_i[15:0]} << hsh);
            end
            default: begin
                ld_data_o = rdata_i;
                merge_o   = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a word-only data memory. Word stores go
// straight through; byte/half stores become a read cycle (with stall) followed
// by a write of the merged word. Loads are lane-selected, extended and
// registered toward MEM/WB.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses are
// dropped and flagged on the misalign output one cycle later. Without it the
// low address bits are ignored and misalign is tied low.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | accept requests; sub-word stores read the word and stall
// ST_RMW_WR | write the registered merge word back, then return to idle
module mem_access_unit
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        dm_mem_read,
    output logic        dm_mem_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign
);

    mau_state_e  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;

    logic        req;
    logic        sub_word;
    logic        trap;
    logic [31:0] word_addr;
    logic [31:0] lane_ld;
    logic [31:0] lane_merge;

    assign req       = ex_valid && (ex_mem_read || ex_mem_write);
    assign sub_word  = (ex_size == SZ_BYTE) || (ex_size == SZ_HALF);
    assign word_addr = {ex_addr[31:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap     = req && is_misaligned(ex_size, ex_addr[1:0]);
    assign misalign = misalign_q;

    // One-cycle flag for a dropped misaligned request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == ST_IDLE) && trap;
        end
    end
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_align (
        .size_i     (ex_size),
        .unsigned_i (ex_unsigned),
        .offset_i   (ex_addr[1:0]),
        .rdata_i    (dm_rdata),
        .wdata_i    (ex_wdata),
        .ld_data_o  (lane_ld),
        .merge_o    (lane_merge)
    );

    // Memory-side strobes, stall and next-state selection.
    always_comb begin
        state_d      = state_q;
        merge_d      = merge_q;
        addr_d       = addr_q;
        ld_data_d    = ld_data_q;
        ld_valid_d   = 1'b0;
        dm_mem_read  = 1'b0;
        dm_mem_write = 1'b0;
        dm_addr      = word_addr;
        dm_wdata     = ex_wdata;
        stall        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !trap) begin
                    if (ex_mem_write) begin
                        if (sub_word) begin
                            dm_mem_read = 1'b1;
                            stall       = 1'b1;
                            merge_d     = lane_merge;
                            addr_d      = word_addr;
                            state_d     = ST_RMW_WR;
                        end else begin
                            dm_mem_write = 1'b1;
                        end
                    end else begin
                        dm_mem_read = 1'b1;
                        ld_data_d   = lane_ld;
                        ld_valid_d  = 1'b1;
                    end
                end
            end
            ST_RMW_WR: begin
                // A reset landing here must not commit the half-finished merge.
                dm_mem_write = rst_n;
                dm_addr      = addr_q;
                dm_wdata     = merge_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, merge buffer and load result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            merge_q    <= '0;
            addr_q     <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            merge_q    <= merge_d;
            addr_q     <= addr_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
        end
    end

    assign ld_data  = ld_data_q;
    assign ld_valid = ld_valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, reset-during-RMW and
// misalignment sequences, then randomized traffic against a byte-array model.
module tb_mem_access_unit;

    localparam bit BE = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, dm_mem_read, dm_mem_write, ld_valid, misalign;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, ld_data;

    logic [31:0] mem [64];
    logic        clr_mem;

    logic [31:0] ref_mem [64];
    logic [31:0] last_ld;
    int          n_checks = 0;
    int          n_pass   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;   // load result for loads, memory word after stores
    } vec_t;

    vec_t vecs [17];

    mem_access_unit #(.BIG_ENDIAN(BE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .stall        (stall),
        .dm_mem_read  (dm_mem_read),
        .dm_mem_write (dm_mem_write),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (dm_mem_write) begin
            mem[dm_addr[7:2]] <= dm_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    // Memory word viewed as four bytes in address order.
    function automatic void split(input logic [31:0] w, output logic [7:0] b [4]);
        for (int i = 0; i < 4; i++) b[i] = BE ? w[31-8*i -: 8] : w[8*i +: 8];
    endfunction

    function automatic logic [31:0] join4(input logic [7:0] b [4]);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (BE) w[31-8*i -: 8] = b[i];
            else    w[8*i +: 8]    = b[i];
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic un);
        logic [7:0]  b [4];
        logic [15:0] h;
        split(w, b);
        if (sz == 2'd0) begin
            return un ? {24'd0, b[off]} : {{24{b[off][7]}}, b[off]};
        end else if (sz == 2'd1) begin
            // lower-addressed byte is the more significant one in big-endian order
            h = BE ? {b[{off[1], 1'b0}], b[{off[1], 1'b1}]} : {b[{off[1], 1'b1}], b[{off[1], 1'b0}]};
            return un ? {16'd0, h} : {{16{h[15]}}, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic [31:0] wd);
        logic [7:0] b [4];
        split(w, b);
        if (sz == 2'd0) begin
            b[off] = wd[7:0];
        end else if (sz == 2'd1) begin
            if (BE) begin
                b[{off[1], 1'b0}] = wd[15:8];
                b[{off[1], 1'b1}] = wd[7:0];
            end else begin
                b[{off[1], 1'b0}] = wd[7:0];
                b[{off[1], 1'b1}] = wd[15:8];
            end
        end else begin
            return wd;
        end
        return join4(b);
    endfunction

    // Called at posedge+1; returns at posedge+1 once the access has completed.
    task automatic run_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic un, input logic [31:0] a, input logic [31:0] wd);
        logic st, ld, sub, trapped;
        st      = v && wr;
        ld      = v && rd && !wr;
        sub     = st && (sz < 2'd2);
        trapped = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((st || ld) && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00))) begin
            trapped = 1'b1;
            st = 1'b0; ld = 1'b0; sub = 1'b0;
        end
`endif
        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr;
        ex_size = sz; ex_unsigned = un; ex_addr = a; ex_wdata = wd;
        #3;
        check("stall", {31'd0, stall}, {31'd0, sub});
        check("dm_mem_read", {31'd0, dm_mem_read}, {31'd0, ld || sub});
        check("dm_mem_write", {31'd0, dm_mem_write}, {31'd0, st && !sub});
        if (st || ld) check("dm_addr", dm_addr, {a[31:2], 2'b00});
        if (st && !sub) check("dm_wdata", dm_wdata, wd);
        if (ld) last_ld = ref_load(ref_mem[a[7:2]], a[1:0], sz, un);
        if (st) ref_mem[a[7:2]] = ref_store(ref_mem[a[7:2]], a[1:0], sz, wd);
        @(posedge clk); #1;
        if (sub) begin
            #2;
            check("rmw_stall", {31'd0, stall}, 32'd0);
            check("rmw_write", {31'd0, dm_mem_write}, 32'd1);
            check("rmw_addr", dm_addr, {a[31:2], 2'b00});
            @(posedge clk); #1;
        end
        check("ld_valid", {31'd0, ld_valid}, {31'd0, ld});
        check("ld_data", ld_data, last_ld);
        check("misalign", {31'd0, misalign}, {31'd0, trapped});
        if (st) check("mem_word", mem[a[7:2]], ref_mem[a[7:2]]);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h11223344};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h123456AA, 32'h11AA3344};
        vecs[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF7F01, 32'h80FF7F01};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h30, 32'h0,        32'hFFFFFF80};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h30, 32'h0,        32'h00000080};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h32, 32'h0,        32'h00007F01};
        vecs[8]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h30, 32'h0,        32'hFFFF80FF};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h30, 32'h0,        32'h000080FF};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0,        32'h00000000};
        vecs[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h42, 32'hAAAABEEF, 32'h0000BEEF};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h40, 32'h00000012, 32'h1200BEEF};
        vecs[13] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h23, 32'h00000055, 32'h11AA3355};
        vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0,        32'hFFFFFFAA};
        vecs[15] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h22, 32'h0,        32'h00000033};
        vecs[16] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        32'h11AA3355};

        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        last_ld = '0;

        rst_n = 1'b0; clr_mem = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_size = 2'd0; ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1; clr_mem = 1'b0;
        #2;
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_dm_en", {30'd0, dm_mem_read, dm_mem_write}, 32'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(1'b1, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].un, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].wr) check($sformatf("tbl%0d_mem", i), mem[vecs[i].addr[7:2]], vecs[i].exp);
            else            check($sformatf("tbl%0d_ld", i), ld_data, vecs[i].exp);
        end

        // misaligned word load
        run_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("lw13_no_valid", {31'd0, ld_valid}, 32'd0);
`else
        check("lw13_ld", ld_data, 32'hDEADBEEF);
`endif
        run_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        // reset landing in the write-back cycle of a byte store
        run_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFEF00D);
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b1;
        ex_size = 2'd0; ex_unsigned = 1'b0; ex_addr = 32'h50; ex_wdata = 32'h77;
        #3;
        check("rstrmw_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("rstrmw_no_write", {31'd0, dm_mem_write}, 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_write = 1'b0;
        rst_n = 1'b1;
        #2;
        check("rstrmw_mem", mem[32'h50 >> 2], 32'hCAFEF00D);
        check("rstrmw_ld_data", ld_data, 32'd0);
        check("rstrmw_idle_stall", {31'd0, stall}, 32'd0);
        check("rstrmw_idle_dm_en", {30'd0, dm_mem_read, dm_mem_write}, 32'd0);
        last_ld = '0;
        @(posedge clk); #1;
        run_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h50, 32'h0);
        check("rstrmw_reload", ld_data, 32'hCAFEF00D);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] r;
            r = $urandom;
            run_op(r[2:0] != 3'd0, r[3], r[4], r[6:5], r[7], {24'd0, r[15:8]}, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the EX/MEM pipeline register and the word-only data memory in the five-stage pipeline. Converts MIPS byte/halfword/word loads and stores into word accesses: sub-word stores become a two-cycle read-modify-write with a pipeline stall; loads are lane-selected, sign- or zero-extended and registered toward MEM/WB.

## Interface
- BIG_ENDIAN, 1: byte 0 of a word is bits 31:24 when 1, bits 7:0 when 0
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  an access is present in EX/MEM
- ex_mem_read  in  1  load request
- ex_mem_write  in  1  store request
- ex_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ex_unsigned  in  1  zero-extend load (LBU/LHU) when 1
- ex_addr  in  32  byte address
- ex_wdata  in  32  store data, right-justified for sub-word
- stall  out  1  hold IF/ID/EX/EX-MEM registers this cycle
- dm_mem_read  out  1  to data memory MemRead
- dm_mem_write  out  1  to data memory MemWrite
- dm_addr  out  32  word-aligned address ({ex_addr[31:2],2'b00})
- dm_wdata  out  32  full word to write
- dm_rdata  in  32  data memory ReadData (combinational, same cycle)
- ld_data  out  32  registered, extended load result
- ld_valid  out  1  ld_data is new this cycle
- misalign  out  1  registered misaligned-access flag (only with MISALIGN_TRAP_EN)

## Operation
- States: IDLE, RMW_WR.
- IDLE, no request (ex_valid=0 or neither read nor write): all dm_* enables 0, stall 0.
- IDLE, word store: dm_mem_write=1, dm_wdata=ex_wdata, stall 0, stay IDLE.
- IDLE, load (any size): dm_mem_read=1; select lane by ex_addr[1:0] (byte) or ex_addr[1] (half) per BIG_ENDIAN; extend to 32 bits; register into ld_data, ld_valid=1 next cycle. Stall 0.
- IDLE, byte/half store: dm_mem_read=1, stall=1; merge ex_wdata[7:0]/[15:0] into dm_rdata lane, register as merge word; go RMW_WR.
- RMW_WR: dm_mem_write=1, dm_wdata=merge word, dm_addr from (held) ex_addr, stall 0; return to IDLE.
- ex_mem_read and ex_mem_write both 1: treated as store; no ld_valid.
- Halfword at ex_addr[0]=1 or word at ex_addr[1:0]!=0 is misaligned; handling per Configuration.
- ld_valid is 1 for exactly one cycle per load; ld_data holds last value otherwise.

## Timing
- Reset values: state IDLE, ld_data 0, ld_valid 0, misalign 0; dm_* outputs and stall combinationally 0 in IDLE with no request.
- Load latency: 1 cycle (request cycle N → ld_data/ld_valid at N+1).
- Word store: written at edge ending cycle N. Sub-word store: read in N (stall=1), write at edge ending N+1.
- Upstream must hold ex_* stable while stall=1.
- rst_n low in RMW_WR: write suppressed (dm_mem_write forced 0 during reset cycle), state→IDLE, merge discarded.
- Back-to-back sub-word stores: each takes 2 cycles; no write-buffer forwarding needed since RMW is serialized.

## Configuration
- MISALIGN_TRAP_EN defined: misaligned access issues no dm_mem_read/dm_mem_write, no stall, no ld_valid; misalign=1 for one cycle after the request cycle.
- Undefined: misalign port tied 0; low address bits ignored for half (bit 0) and word (bits 1:0), access proceeds as aligned.

## Structure
- Shared package mem_pkg: size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD), state enum type, lane-select helper functions.
- One sub-module: mem_lane_align — combinational lane extract/extend for loads and lane merge for stores, parameterised by BIG_ENDIAN.

## Test plan
- Word store 0xDEADBEEF to 0x10, then LW 0x10 → dm write in 1 cycle, stall never 1; ld_data=0xDEADBEEF one cycle later, ld_valid pulse.
- Memory word 0x11223344 at 0x20, SB 0xAA to 0x21 (BIG_ENDIAN=1) → stall 1 for one cycle, memory becomes 0x11AA3344.
- Word 0x80FF7F01 at 0x30: LB 0x30 → 0xFFFFFF80; LBU 0x30 → 0x00000080; LH 0x32 → 0x00007F01; LH 0x30 → 0xFFFF80FF.
- SH 0xBEEF to 0x42 over 0x00000000 → memory 0x0000BEEF after 2 cycles; immediately followed SB 0x12 to 0x40 → 0x1200BEEF.
- rst_n low during RMW_WR of SB to 0x50 → memory at 0x50 unchanged, ld_data 0, state IDLE.
- With MISALIGN_TRAP_EN, LW 0x13 → no dm enables, misalign=1 next cycle, ld_valid 0; without macro, LW 0x13 returns word at 0x10.
